pwm_timer: RTL

Memory-mapped 4-channel PWM timer, a bus slave decoded by the top-level address decoder at 0x8000_0500–0x8000_051f alongside systick, uart, spi and gpio. It consumes the CPU native memory bus (select/wstrb/addr/data_i → ready/data_o). It drives four PWM outputs, which are routed to gpio alternate functions, and one level interrupt to the CPU irq vector. Compare and period values are double-buffered, so reloads happen only at period boundaries and never cause glitches.

---
 rtl/pwm_timer_pkg.sv | 31 +++
 rtl/pwm_channel.sv | 44 ++++
 rtl/pwm_timer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pwm_timer_pkg.sv
// Shared register map, bit positions and byte-strobe merge helper for the
// 4-channel PWM timer; firmware headers mirror these values.
package pwm_timer_pkg;

  localparam logic [4:0] PWM_CTRL   = 5'h00;
  localparam logic [4:0] PWM_PRESC  = 5'h04;
  localparam logic [4:0] PWM_PERIOD = 5'h08;
  localparam logic [4:0] PWM_STATUS = 5'h0C;
  localparam logic [4:0] PWM_CMP0   = 5'h10;
  localparam logic [4:0] PWM_CMP1   = 5'h14;
  localparam logic [4:0] PWM_CMP2   = 5'h18;
  localparam logic [4:0] PWM_CMP3   = 5'h1C;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STATUS_FLAG_BIT = 0;
  localparam int NUM_CH          = 4;

  // Merge new write data into an old register image, one byte per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: byte-strobed compare shadow, active copy reloaded
// at period wrap (or continuously while disabled) and a registered output.
module pwm_channel
  import pwm_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 wr,
  input  logic [3:0]           wstrb,
  input  logic [31:0]          data_i,
  input  logic                 wrap,
  input  logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] cmp_sh,
  output logic                 pwm
);

  logic [CNT_WIDTH-1:0] cmp_sh_r;
  logic [CNT_WIDTH-1:0] cmp_act_r;
  logic                 pwm_r;

  // Shadow write, glitch-free reload of the active compare and output compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_sh_r  <= {CNT_WIDTH{1'b0}};
      cmp_act_r <= {CNT_WIDTH{1'b0}};
      pwm_r     <= 1'b0;
    end else begin
      if (wr) begin
        cmp_sh_r <= CNT_WIDTH'(apply_wstrb(32'(cmp_sh_r), data_i, wstrb));
      end
      if (!en || wrap) begin
        cmp_act_r <= cmp_sh_r;
      end
      pwm_r <= en & (cnt < cmp_act_r);
    end
  end

  assign cmp_sh = cmp_sh_r;
  assign pwm    = pwm_r;

endmodule

// File: rtl/pwm_timer.sv
// Memory-mapped 4-channel PWM timer: bus slave decode, prescaler, period
// counter, period flag/interrupt and read-back mux.
module pwm_timer
  import pwm_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [4:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic [3:0]  pwm_out,
  output logic        irq
);

  logic                 ready_r;
  logic [31:0]          data_o_r;
  logic                 en_r;
  logic                 irq_en_r;
  logic                 flag_r;
  logic [CNT_WIDTH-1:0] presc_r;
  logic [CNT_WIDTH-1:0] period_sh_r;
  logic [CNT_WIDTH-1:0] period_act_r;
  logic [CNT_WIDTH-1:0] pre_cnt_r;
  logic [CNT_WIDTH-1:0] cnt_r;

  logic                 access_s;
  logic                 wr_s;
  logic                 rd_s;
  logic                 tick_s;
  logic                 wrap_s;
  logic [4:0]           word_addr_s;
  logic [3:0]           cmp_wr_s;
  logic [31:0]          ctrl_w_s;
  logic [31:0]          rdata_s;
  logic [3:0]           pwm_s;
  logic [CNT_WIDTH-1:0] cmp_sh_s [NUM_CH];
  logic                 unused_s;

  // Byte lanes within a word are not decoded.
  assign unused_s = ^addr[1:0];

  // Access qualification, register decode and timebase events.
  always_comb begin
    access_s    = select & ~ready_r;
    wr_s        = access_s & (wstrb != 4'h0);
    rd_s        = access_s & (wstrb == 4'h0);
    word_addr_s = {addr[4:2], 2'b00};
    tick_s      = en_r & (pre_cnt_r == presc_r);
    wrap_s      = tick_s & (cnt_r == period_act_r);
    ctrl_w_s    = apply_wstrb(32'({irq_en_r, en_r}), data_i, wstrb);
    cmp_wr_s    = 4'h0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp_wr_s[i] = wr_s & (word_addr_s == (PWM_CMP0 + 5'(4 * i)));
    end
  end

  // Read-back mux; unused bits read as zero.
  always_comb begin
    rdata_s = 32'h0;
    case (word_addr_s)
      PWM_CTRL:   rdata_s = {30'h0, irq_en_r, en_r};
      PWM_PRESC:  rdata_s = 32'(presc_r);
      PWM_PERIOD: rdata_s = 32'(period_sh_r);
      PWM_STATUS: rdata_s = {16'(cnt_r), 15'h0, flag_r};
      PWM_CMP0:   rdata_s = 32'(cmp_sh_s[0]);
      PWM_CMP1:   rdata_s = 32'(cmp_sh_s[1]);
      PWM_CMP2:   rdata_s = 32'(cmp_sh_s[2]);
      PWM_CMP3:   rdata_s = 32'(cmp_sh_s[3]);
      default:    rdata_s = 32'h0;
    endcase
  end

  // Bus handshake: one-cycle ready pulse with registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_r  <= 1'b0;
      data_o_r <= 32'h0;
    end else begin
      ready_r  <= select & ~ready_r;
      data_o_r <= rd_s ? rdata_s : 32'h0;
    end
  end

  // Control, prescaler and period shadow registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_r        <= 1'b0;
      irq_en_r    <= 1'b0;
      presc_r     <= {CNT_WIDTH{1'b0}};
      period_sh_r <= {CNT_WIDTH{1'b0}};
    end else if (wr_s) begin
      if (word_addr_s == PWM_CTRL) begin
        en_r     <= ctrl_w_s[CTRL_EN_BIT];
        irq_en_r <= ctrl_w_s[CTRL_IRQ_EN_BIT];
      end
      if (word_addr_s == PWM_PRESC) begin
        presc_r <= CNT_WIDTH'(apply_wstrb(32'(presc_r), data_i, wstrb));
      end
      if (word_addr_s == PWM_PERIOD) begin
        period_sh_r <= CNT_WIDTH'(apply_wstrb(32'(period_sh_r), data_i, wstrb));
      end
    end
  end

  // Prescaler and period counter; the active period follows the shadow while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_r    <= {CNT_WIDTH{1'b0}};
      cnt_r        <= {CNT_WIDTH{1'b0}};
      period_act_r <= {CNT_WIDTH{1'b0}};
    end else if (!en_r) begin
      pre_cnt_r    <= {CNT_WIDTH{1'b0}};
      cnt_r        <= {CNT_WIDTH{1'b0}};
      period_act_r <= period_sh_r;
    end else begin
      pre_cnt_r <= tick_s ? {CNT_WIDTH{1'b0}} : pre_cnt_r + CNT_WIDTH'(1);
      if (wrap_s) begin
        cnt_r        <= {CNT_WIDTH{1'b0}};
        period_act_r <= period_sh_r;
      end else if (tick_s) begin
        cnt_r <= cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  // Period flag: a wrap takes priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_r <= 1'b0;
    end else if (wrap_s) begin
      flag_r <= 1'b1;
    end else if (wr_s && (word_addr_s == PWM_STATUS) && wstrb[0] && data_i[STATUS_FLAG_BIT]) begin
      flag_r <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (en_r),
      .wr     (cmp_wr_s[g]),
      .wstrb  (wstrb),
      .data_i (data_i),
      .wrap   (wrap_s),
      .cnt    (cnt_r),
      .cmp_sh (cmp_sh_s[g]),
      .pwm    (pwm_s[g])
    );
  end

  assign ready   = ready_r;
  assign data_o  = data_o_r;
  assign pwm_out = pwm_s;
  assign irq     = flag_r & irq_en_r;

endmodule
